// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port memory.
// Byte-lane merge is width-generic via a wide carrier vector.
package mem_pkg;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_e;

  localparam int unsigned MAX_W  = 256;
  localparam int unsigned MAX_IW = $clog2(MAX_W);

  // Bit i takes new_w when the lane holding it is enabled.
  function automatic logic [MAX_W-1:0] be_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] be,
    input int unsigned      lane_w
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (be[MAX_IW'(i / lane_w)]) begin
        r[MAX_IW'(i)] = new_w[MAX_IW'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer for memory_dp.
// Sweeps every address once, then parks in READY.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int unsigned LENGTH         = 256,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(LENGTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and sweep counter; a reset restarts the sweep at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state_q <= CLEAR;
      else                state_q <= READY;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One zero write per edge until the last address is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST) state_d = READY;
      end
      READY: begin
      end
      default: begin
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/memory_dp.sv
// Dual-port RAM: port A read/write with byte lanes,
// port B read-only, registered reads, clear-on-reset.
module memory_dp
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned LENGTH         = 256,
  parameter int unsigned ADDR_WIDTH     = $clog2(LENGTH),
  parameter int unsigned BYTE_W         = 8,
  parameter rdw_mode_e   RDW_MODE       = RDW_READ_FIRST,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned NBE           = WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NBE-1:0]        a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wd,
  output logic [WIDTH-1:0]      a_rd,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WIDTH-1:0]      b_rd,
  output logic                  b_rvalid
);

  localparam logic [ADDR_WIDTH:0] LEN =
    (ADDR_WIDTH + 1)'(LENGTH);
  localparam bit WF = (RDW_MODE == RDW_WRITE_FIRST);

  logic [WIDTH-1:0] mem [LENGTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  a_acc, b_acc;
  logic                  a_inr, b_inr, a_wr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata, a_merged;
  logic [WIDTH-1:0]      a_old, b_old, a_val, b_val;

  logic [WIDTH-1:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic             a_rv_q, a_rv_d, b_rv_q, b_rv_d;

  mem_clear_seq #(
    .LENGTH         (LENGTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Port decode, write-port mux and read data selection.
  always_comb begin
    a_acc = a_en & ~busy;
    b_acc = b_en & ~busy;
    a_inr = {1'b0, a_addr} < LEN;
    b_inr = {1'b0, b_addr} < LEN;
    a_wr  = a_acc & a_we & a_inr;
    a_old = a_inr ? mem[a_addr] : '0;
    b_old = b_inr ? mem[b_addr] : '0;
    a_merged = WIDTH'(be_merge(MAX_W'(a_old),
                               MAX_W'(a_wd),
                               MAX_W'(a_be),
                               BYTE_W));
    we    = clr_we | a_wr;
    waddr = clr_we ? clr_addr : a_addr;
    wdata = clr_we ? '0 : a_merged;
    a_val = (WF && a_wr) ? a_merged : a_old;
    b_val = b_old;
    if (WF && a_wr && (a_addr == b_addr)) b_val = a_merged;
    a_rd_d = a_acc ? a_val : a_rd_q;
    b_rd_d = b_acc ? b_val : b_rd_q;
    a_rv_d = a_acc;
    b_rv_d = b_acc;
  end

  // Array write port; contents are cleared by the sweep, not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data and valid strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      a_rd_q <= a_rd_d;
      b_rd_q <= b_rd_d;
      a_rv_q <= a_rv_d;
      b_rv_q <= b_rv_d;
    end
  end

  assign a_rd     = a_rd_q;
  assign b_rd     = b_rd_q;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: two instances share stimulus,
// u0 (256 words, read-first) and u1 (200 words, write-first).
module tb_memory_dp;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en;
  logic [3:0]  a_be;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wd;

  logic        busy0, busy1;
  logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
  logic        a_rv0, b_rv0, a_rv1, b_rv1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_dp #(
    .WIDTH (32), .LENGTH (256), .BYTE_W (8),
    .RDW_MODE (RDW_READ_FIRST), .CLEAR_ON_RESET (1'b1)
  ) u0 (
    .clk (clk), .rst_n (rst_n), .busy (busy0),
    .a_en (a_en), .a_we (a_we), .a_be (a_be),
    .a_addr (a_addr), .a_wd (a_wd),
    .a_rd (a_rd0), .a_rvalid (a_rv0),
    .b_en (b_en), .b_addr (b_addr),
    .b_rd (b_rd0), .b_rvalid (b_rv0)
  );

  memory_dp #(
    .WIDTH (32), .LENGTH (200), .BYTE_W (8),
    .RDW_MODE (RDW_WRITE_FIRST), .CLEAR_ON_RESET (1'b1)
  ) u1 (
    .clk (clk), .rst_n (rst_n), .busy (busy1),
    .a_en (a_en), .a_we (a_we), .a_be (a_be),
    .a_addr (a_addr), .a_wd (a_wd),
    .a_rd (a_rd1), .a_rvalid (a_rv1),
    .b_en (b_en), .b_addr (b_addr),
    .b_rd (b_rd1), .b_rvalid (b_rv1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
    a_be = 4'h0; a_addr = '0; b_addr = '0;
    a_wd = '0;
  endtask

  task automatic awrite(input logic [7:0] ad,
                        input logic [31:0] d,
                        input logic [3:0] be);
    a_en = 1'b1; a_we = 1'b1; a_addr = ad;
    a_wd = d; a_be = be;
  endtask

  task automatic bread(input logic [7:0] ad);
    b_en = 1'b1; b_addr = ad;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy0 && n < 400) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    int n, n1;
    idle();
    rst_n = 1'b0;
    cyc(); cyc();
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b%b want 11",
               busy0, busy1);
    end
    checks++;
    if ({a_rv0, b_rv0, a_rv1, b_rv1} !== 4'b0 ||
        a_rd0 !== 32'h0 || b_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: rv=%b a_rd0=%h b_rd1=%h",
               {a_rv0, b_rv0, a_rv1, b_rv1}, a_rd0, b_rd1);
    end
    rst_n = 1'b1;
    n = 0; n1 = 0;
    while (busy0 && n < 400) begin
      if (n == 50) begin
        awrite(8'd3, 32'hFFFF_FFFF, 4'hF);
        bread(8'd3);
      end else begin
        idle();
      end
      cyc();
      n++;
      if (!busy1 && n1 == 0) n1 = n;
      if (n == 51) begin
        checks++;
        if ({a_rv0, b_rv0, a_rv1, b_rv1} !== 4'b0) begin
          errors++;
          $display("FAIL busy_drop_rv: got %b want 0000",
                   {a_rv0, b_rv0, a_rv1, b_rv1});
        end
      end
    end
    idle();
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL sweep_len256: got %0d want 256", n);
    end
    checks++;
    if (n1 != 200) begin
      errors++;
      $display("FAIL sweep_len200: got %0d want 200", n1);
    end
    a_en = 1'b1; a_addr = 8'd0; bread(8'd3);
    cyc();
    checks++;
    if (a_rv0 !== 1'b1 || a_rd0 !== 32'h0 ||
        b_rv0 !== 1'b1 || b_rd0 !== 32'h0) begin
      errors++;
      $display("FAIL first_read: a=%b/%h b=%b/%h want 1/0",
               a_rv0, a_rd0, b_rv0, b_rd0);
    end
    idle();
  endtask

  task automatic test_restart();
    int n;
    awrite(8'd0, 32'hAAAA_AAAA, 4'hF); cyc();
    awrite(8'd128, 32'hAAAA_AAAA, 4'hF); cyc();
    awrite(8'd255, 32'hAAAA_AAAA, 4'hF); cyc();
    idle(); bread(8'd128); cyc();
    checks++;
    if (b_rd0 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL preload: got %h want aaaaaaaa", b_rd0);
    end
    idle();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b1 || b_rd0 !== 32'h0 ||
        b_rv0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b b_rd=%h rv=%b",
               busy0, b_rd0, b_rv0);
    end
    cyc();
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL restart_len: got %0d want 256", n);
    end
    a_en = 1'b1; a_addr = 8'd0; bread(8'd128); cyc();
    checks++;
    if (a_rd0 !== 32'h0 || b_rd0 !== 32'h0) begin
      errors++;
      $display("FAIL cleared_0_128: got %h %h want 0 0",
               a_rd0, b_rd0);
    end
    idle(); bread(8'd255); cyc();
    checks++;
    if (b_rd0 !== 32'h0) begin
      errors++;
      $display("FAIL cleared_255: got %h want 0", b_rd0);
    end
    idle();
  endtask

  task automatic test_byte_en();
    awrite(8'd5, 32'h1122_3344, 4'b1111); cyc();
    awrite(8'd5, 32'hAABB_CCDD, 4'b0101); cyc();
    checks++;
    if (a_rv0 !== 1'b1 || a_rd0 !== 32'h1122_3344) begin
      errors++;
      $display("FAIL write_reads: rv=%b rd=%h want 1/11223344",
               a_rv0, a_rd0);
    end
    awrite(8'd5, 32'hFFFF_FFFF, 4'b0000); cyc();
    idle(); bread(8'd5); cyc();
    checks++;
    if (b_rv0 !== 1'b1 || b_rd0 !== 32'h11BB_33DD ||
        b_rd1 !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL byte_en: rv=%b got %h %h want 11bb33dd",
               b_rv0, b_rd0, b_rd1);
    end
    idle(); cyc();
    checks++;
    if (b_rv0 !== 1'b0 || b_rd0 !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL rd_hold: rv=%b rd=%h want 0/11bb33dd",
               b_rv0, b_rd0);
    end
  endtask

  task automatic test_rdw();
    awrite(8'd7, 32'h10, 4'hF); cyc();
    awrite(8'd7, 32'h20, 4'hF); bread(8'd7); cyc();
    checks++;
    if (b_rd0 !== 32'h10 || a_rd0 !== 32'h10) begin
      errors++;
      $display("FAIL rdw_rf: got a=%h b=%h want 10",
               a_rd0, b_rd0);
    end
    checks++;
    if (b_rd1 !== 32'h20 || a_rd1 !== 32'h20) begin
      errors++;
      $display("FAIL rdw_wf: got a=%h b=%h want 20",
               a_rd1, b_rd1);
    end
    awrite(8'd7, 32'h0000_3300, 4'b0010);
    bread(8'd7); cyc();
    checks++;
    if (b_rd0 !== 32'h20 || b_rd1 !== 32'h3320) begin
      errors++;
      $display("FAIL rdw_part: got %h %h want 20 3320",
               b_rd0, b_rd1);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      awrite(8'(i), 32'(i), 4'hF);
      cyc();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      bread(8'(i));
      cyc();
      checks++;
      if (b_rv0 !== 1'b1 || b_rd0 !== 32'(i) ||
          b_rd1 !== 32'(i)) begin
        errors++;
        $display("FAIL stream[%0d]: rv=%b got %h %h want %h",
                 i, b_rv0, b_rd0, b_rd1, 32'(i));
      end
    end
    idle(); cyc();
    checks++;
    if (b_rv0 !== 1'b0) begin
      errors++;
      $display("FAIL stream_end_rv: got %b want 0", b_rv0);
    end
  endtask

  task automatic test_range();
    awrite(8'd210, 32'hDEAD_BEEF, 4'hF); cyc();
    checks++;
    if (a_rv1 !== 1'b1 || a_rd1 !== 32'h0) begin
      errors++;
      $display("FAIL oor_wr: rv=%b rd=%h want 1/0",
               a_rv1, a_rd1);
    end
    awrite(8'd199, 32'h1234_5678, 4'hF); cyc();
    idle(); bread(8'd210); cyc();
    checks++;
    if (b_rv1 !== 1'b1 || b_rd1 !== 32'h0 ||
        b_rd0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL oor_rd: rv=%b got %h %h want 1/0/deadbeef",
               b_rv1, b_rd1, b_rd0);
    end
    bread(8'd199); cyc();
    checks++;
    if (b_rd1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL last_addr: got %h want 12345678", b_rd1);
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_restart();
    test_byte_en();
    test_rdw();
    test_back_to_back();
    test_range();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
